// File: rtl/ext_mem_responder_pkg.sv
// Shared definitions for the external memory responder.
// Holds the default bus widths and burst length shared with the cache side,
// the responder FSM state type and a small width helper for counters.
package ext_mem_responder_pkg;

    localparam int unsigned MemDataBits   = 128;
    localparam int unsigned MemAddrBits   = 28;
    localparam int unsigned MemTagBits    = 5;
    localparam int unsigned MemBurstBeats = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWdata,
        StWait,
        StRresp
    } state_e;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Cache-to-memory request/data/response bundle.
// master: cache side, drives requests and write beats, receives read beats.
// slave:  memory side, drives the ready signals and the read response.
interface ext_mem_responder_if
    import ext_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_BITS = MemDataBits,
    parameter int unsigned ADDR_BITS = MemAddrBits,
    parameter int unsigned TAG_BITS  = MemTagBits
) ();

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [TAG_BITS-1:0]    mem_resp_tag;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );

endinterface

// File: rtl/ext_mem_ram.sv
// Single-port, byte-masked RAM with a registered synchronous read port.
// Ports:
//   clk, reset   clock and asynchronous active-low reset (read register only)
//   en, we       access enable; we=1 writes, we=0 reads into rdata
//   addr         beat index
//   wdata, wmask write data and per-byte enables (bit i covers byte i)
//   rdata        read data, holds its value until the next read
module ext_mem_ram #(
    parameter int unsigned DATA_BITS  = 128,
    parameter int unsigned DEPTH_LOG2 = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wmask,
    output logic [DATA_BITS-1:0]   rdata
);

    localparam int unsigned Bytes = DATA_BITS / 8;
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    // Array contents survive reset so a preloaded image stays intact.
    logic [DATA_BITS-1:0] ram [Depth];
    logic [DATA_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < Bytes; b++) begin
                if (wmask[b]) begin
                    ram[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (en && !we) begin
            rdata_q <= ram[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Synthesizable memory responder for the cache line interface.
// Accepts one line request at a time: writes take BEATS masked data beats into
// the RAM, reads return BEATS response beats LATENCY cycles after acceptance.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    request/data/response bundle (slave side)
module ext_mem_responder
    import ext_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_BITS  = MemDataBits,
    parameter int unsigned ADDR_BITS  = MemAddrBits,
    parameter int unsigned TAG_BITS   = MemTagBits,
    parameter int unsigned BEATS      = MemBurstBeats,
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned LATENCY    = 8
) (
    input  logic               clk,
    input  logic               reset,
    ext_mem_responder_if.slave bus
);

    localparam int unsigned BeatW = cnt_width(BEATS);
    localparam int unsigned LatW  = cnt_width(LATENCY);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
    localparam logic [ADDR_BITS-1:0] LineMask = ~ADDR_BITS'(BEATS - 1);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [TAG_BITS-1:0]   resp_tag_q, resp_tag_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic                  ready_q;

    logic                  ram_en;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_BITS-1:0]  ram_rdata;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        tag_d      = tag_q;
        resp_tag_d = resp_tag_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = base_q + DEPTH_LOG2'(beat_q);

        unique case (state_q)
            StIdle: begin
                if (bus.mem_req_valid && ready_q) begin
                    // Truncating the aligned line address wraps it into the RAM.
                    base_d = DEPTH_LOG2'(bus.mem_req_addr & LineMask);
                    tag_d  = bus.mem_req_tag;
                    beat_d = '0;
                    if (bus.mem_req_rw) begin
                        state_d = StWdata;
                    end else begin
                        lat_d   = LatW'(LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWdata: begin
                if (bus.mem_req_data_valid) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StWait: begin
                if (lat_q == '0) begin
                    // Beat 0 is read one cycle ahead so it lands as the first response.
                    ram_en     = 1'b1;
                    ram_addr   = base_q;
                    resp_tag_d = tag_q;
                    beat_d     = '0;
                    state_d    = StRresp;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StRresp: begin
                if (beat_q == LastBeat) begin
                    state_d = StIdle;
                end else begin
                    ram_en   = 1'b1;
                    ram_addr = base_q + DEPTH_LOG2'(beat_q + BeatW'(1));
                    beat_d   = beat_q + BeatW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            tag_q      <= '0;
            resp_tag_q <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            tag_q      <= tag_d;
            resp_tag_q <= resp_tag_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            ready_q    <= (state_d == StIdle);
        end
    end

    ext_mem_ram #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.mem_req_data_bits),
        .wmask (bus.mem_req_data_mask),
        .rdata (ram_rdata)
    );

    assign bus.mem_req_ready      = ready_q;
    assign bus.mem_req_data_ready = (state_q == StWdata);
    assign bus.mem_resp_valid     = (state_q == StRresp);
    assign bus.mem_resp_tag       = resp_tag_q;
    assign bus.mem_resp_data      = ram_rdata;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: a table of directed line
// transactions, hand-written corner sequences and a randomized phase, all
// checked against a line-level memory model kept in the bench.
module tb_ext_mem_responder;

    localparam int unsigned DB    = 128;
    localparam int unsigned AB    = 28;
    localparam int unsigned TB    = 5;
    localparam int unsigned BEATS = 4;
    localparam int unsigned DL    = 14;
    localparam int unsigned LAT   = 8;
    localparam int unsigned DEPTH = 1 << DL;

    typedef logic [BEATS-1:0][DB-1:0]   line_t;
    typedef logic [BEATS-1:0][DB/8-1:0] mask_t;

    typedef struct {
        int unsigned   cyc;
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
    } beat_t;

    typedef struct {
        logic          rw;
        logic [AB-1:0] addr;
        logic [TB-1:0] tag;
        line_t         data;
        mask_t         mask;
        line_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    ext_mem_responder_if bus ();

    ext_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t rq[$];
    always @(negedge clk) begin
        if (bus.mem_resp_valid === 1'b1) begin
            rq.push_back('{cyc: cyc, tag: bus.mem_resp_tag, data: bus.mem_resp_data});
        end
    end

    logic [DB-1:0] model [DEPTH];
    int tests = 0;
    int fails = 0;
    vec_t vecs [8];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic int unsigned line_index(input logic [AB-1:0] addr, input int unsigned k);
        int unsigned base;
        base = (int'(addr) / BEATS) * BEATS;
        return (base + k) % DEPTH;
    endfunction

    function automatic line_t model_line(input logic [AB-1:0] addr);
        line_t r;
        for (int k = 0; k < BEATS; k++) r[k] = model[line_index(addr, k)];
        return r;
    endfunction

    task automatic do_write(input logic [AB-1:0] addr, input logic [TB-1:0] tag,
                            input line_t data, input mask_t mask, input int gap,
                            input string name);
        int n;
        int rq0;
        rq0 = rq.size();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_req_addr  = addr;
        bus.mem_req_tag   = tag;
        n = 0;
        while (bus.mem_req_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (bus.mem_req_ready !== 1'b1) begin
            fail_timeout({name, "_req"});
            bus.mem_req_valid = 1'b0;
            return;
        end
        step();
        bus.mem_req_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus.mem_req_data_valid = 1'b0;
                step();
            end
            bus.mem_req_data_valid = 1'b1;
            bus.mem_req_data_bits  = data[k];
            bus.mem_req_data_mask  = mask[k];
            n = 0;
            while (bus.mem_req_data_ready !== 1'b1 && n < 50) begin step(); n++; end
            if (bus.mem_req_data_ready !== 1'b1) begin
                fail_timeout({name, "_data"});
                bus.mem_req_data_valid = 1'b0;
                return;
            end
            if (k == BEATS - 1) check({name, "_ready_busy"}, DB'(bus.mem_req_ready), DB'(0));
            step();
        end
        bus.mem_req_data_valid = 1'b0;
        check({name, "_ready_back"}, DB'(bus.mem_req_ready), DB'(1));
        check({name, "_data_ready_off"}, DB'(bus.mem_req_data_ready), DB'(0));
        check({name, "_no_resp"}, DB'(rq.size()), DB'(rq0));
        for (int k = 0; k < BEATS; k++) begin
            for (int b = 0; b < DB / 8; b++) begin
                if (mask[k][b]) model[line_index(addr, k)][b*8 +: 8] = data[k][b*8 +: 8];
            end
        end
    endtask

    task automatic check_burst(input int unsigned acc, input logic [TB-1:0] tag,
                               input line_t exp, input string name);
        int n;
        beat_t bt;
        n = 0;
        while (rq.size() < BEATS && n < LAT + BEATS + 20) begin step(); n++; end
        if (rq.size() < BEATS) begin
            fail_timeout({name, "_beats"});
            rq.delete();
            return;
        end
        for (int k = 0; k < BEATS; k++) begin
            bt = rq.pop_front();
            check($sformatf("%s_b%0d_cycle", name, k), DB'(bt.cyc), DB'(acc + LAT + k));
            check($sformatf("%s_b%0d_tag", name, k), DB'(bt.tag), DB'(tag));
            check($sformatf("%s_b%0d_data", name, k), bt.data, exp[k]);
        end
    endtask

    task automatic do_read(input logic [AB-1:0] addr, input logic [TB-1:0] tag,
                           input line_t exp, input string name);
        int n;
        int hi;
        int unsigned acc;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = addr;
        bus.mem_req_tag   = tag;
        n = 0;
        while (bus.mem_req_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (bus.mem_req_ready !== 1'b1) begin
            fail_timeout({name, "_req"});
            bus.mem_req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        step();
        bus.mem_req_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < LAT + BEATS; i++) begin
            if (bus.mem_req_ready !== 1'b0) hi++;
            step();
        end
        check({name, "_ready_low"}, DB'(hi), DB'(0));
        check({name, "_ready_back"}, DB'(bus.mem_req_ready), DB'(1));
        check_burst(acc, tag, exp, name);
    endtask

    task automatic build_table();
        line_t a, p, b, ones, wmix, emix;
        mask_t full, mmix;
        full = '1;
        for (int k = 0; k < BEATS; k++) begin
            a[k]    = {4{32'hA0A0_0000 + 32'(k)}};
            p[k]    = {4{32'h5555_0000 + 32'(k)}};
            b[k]    = {4{32'hB00B_0000 + 32'(k)}};
            ones[k] = '1;
        end
        wmix = ones;
        wmix[1][7:0] = 8'hAB;
        mmix = full;
        mmix[1] = 16'h0001;
        emix = ones;
        emix[1] = {p[1][DB-1:8], 8'hAB};
        vecs[0] = '{rw: 1'b1, addr: 28'h0000000, tag: 5'd1, data: a,    mask: full, exp: '0};
        vecs[1] = '{rw: 1'b0, addr: 28'h0000002, tag: 5'd5, data: '0,   mask: '0,   exp: a};
        vecs[2] = '{rw: 1'b1, addr: 28'h0000010, tag: 5'd2, data: p,    mask: full, exp: '0};
        vecs[3] = '{rw: 1'b1, addr: 28'h0000010, tag: 5'd3, data: wmix, mask: mmix, exp: '0};
        vecs[4] = '{rw: 1'b0, addr: 28'h0000010, tag: 5'd3, data: '0,   mask: '0,   exp: emix};
        vecs[5] = '{rw: 1'b1, addr: 28'h0000004, tag: 5'd4, data: b,    mask: full, exp: '0};
        vecs[6] = '{rw: 1'b0, addr: 28'h0004004, tag: 5'd7, data: '0,   mask: '0,   exp: b};
        vecs[7] = '{rw: 1'b0, addr: 28'h0000004, tag: 5'd8, data: '0,   mask: '0,   exp: b};
    endtask

    function automatic line_t rand_line();
        line_t r;
        for (int k = 0; k < BEATS; k++) r[k] = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned acc1, acc2;
        logic [AB-1:0] ra;
        mask_t full;
        mask_t rm;
        full = '1;

        reset = 1'b1;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_rw = 1'b0;
        bus.mem_req_addr = '0;
        bus.mem_req_tag = '0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits = '0;
        bus.mem_req_data_mask = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_ready", DB'(bus.mem_req_ready), DB'(0));
        check("rst_data_ready", DB'(bus.mem_req_data_ready), DB'(0));
        check("rst_resp_valid", DB'(bus.mem_resp_valid), DB'(0));
        check("rst_resp_tag", DB'(bus.mem_resp_tag), DB'(0));
        check("rst_resp_data", bus.mem_resp_data, DB'(0));
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_release_ready", DB'(bus.mem_req_ready), DB'(1));

        // Directed table.
        build_table();
        foreach (vecs[i]) begin
            if (vecs[i].rw) begin
                do_write(vecs[i].addr, vecs[i].tag, vecs[i].data, vecs[i].mask, 0,
                         $sformatf("vec%0d", i));
            end else begin
                do_read(vecs[i].addr, vecs[i].tag, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        // Write with data_valid toggling every other cycle.
        do_write(28'h20, 5'd6, rand_line(), full, 1, "gap_wr");
        do_read(28'h20, 5'd9, model_line(28'h20), "gap_rd");

        // Back-to-back reads: second request held valid during the first burst.
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 28'h0;
        bus.mem_req_tag   = 5'd10;
        n = 0;
        while (bus.mem_req_ready !== 1'b1 && n < 50) begin step(); n++; end
        acc1 = cyc + 1;
        step();
        bus.mem_req_addr = 28'h10;
        bus.mem_req_tag  = 5'd11;
        n = 0;
        while (bus.mem_req_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (bus.mem_req_ready !== 1'b1) begin
            fail_timeout("b2b_req2");
        end else begin
            acc2 = cyc + 1;
            check("b2b_accept_cycle", DB'(acc2), DB'(acc1 + LAT + BEATS + 1));
            step();
            bus.mem_req_valid = 1'b0;
            check_burst(acc1, 5'd10, model_line(28'h0), "b2b_first");
            check_burst(acc2, 5'd11, model_line(28'h10), "b2b_second");
        end
        bus.mem_req_valid = 1'b0;
        repeat (2) step();

        // Reset asserted during beat 2 of a read.
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 28'h4;
        bus.mem_req_tag   = 5'd13;
        n = 0;
        while (bus.mem_req_ready !== 1'b1 && n < 50) begin step(); n++; end
        acc1 = cyc + 1;
        step();
        bus.mem_req_valid = 1'b0;
        n = 0;
        while (cyc < acc1 + LAT + 2 && n < 50) begin step(); n++; end
        check("mid_rst_in_burst", DB'(bus.mem_resp_valid), DB'(1));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ready", DB'(bus.mem_req_ready), DB'(0));
        check("mid_rst_data_ready", DB'(bus.mem_req_data_ready), DB'(0));
        check("mid_rst_resp_valid", DB'(bus.mem_resp_valid), DB'(0));
        check("mid_rst_resp_tag", DB'(bus.mem_resp_tag), DB'(0));
        check("mid_rst_resp_data", bus.mem_resp_data, DB'(0));
        repeat (2) step();
        reset = 1'b1;
        step();
        check("mid_rst_ready_back", DB'(bus.mem_req_ready), DB'(1));
        repeat (LAT + BEATS) step();
        check("mid_rst_beats_seen", DB'(rq.size()), DB'(3));
        rq.delete();
        do_read(28'h4, 5'd12, model_line(28'h4), "post_rst_rd");

        // Randomized phase over a fully initialised region.
        for (int i = 0; i < 16; i++) begin
            do_write(28'(32'h100 + 32'(i) * 4), 5'(i), rand_line(), full, 0,
                     $sformatf("init%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            ra = {14'($urandom_range(0, 16383)),
                  14'(32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)))};
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BEATS; k++) rm[k] = 16'($urandom);
                do_write(ra, 5'($urandom), rand_line(), rm, int'($urandom_range(0, 1)),
                         $sformatf("rnd%0d_wr", i));
            end else begin
                do_read(ra, 5'($urandom), model_line(ra), $sformatf("rnd%0d_rd", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
Synthesizable responder for the cache-to-memory request/data/response interface. It sits below riscv_top in FPGA and synthesis builds, where the behavioural memory model cannot be used. It accepts one line request at a time. Write lines are taken as BEATS masked data beats into an internal RAM. Read lines are returned as BEATS response beats after a fixed latency.

Parameters:
DATA_BITS, 128, beat width (`MEM_DATA_BITS)
ADDR_BITS, 28, request address width in 16-byte units (`MEM_ADDR_BITS)
TAG_BITS, 5, request/response tag width (`MEM_TAG_BITS)
BEATS, 4, beats per line; power of two, >=1
DEPTH_LOG2, 14, log2 of RAM depth in beats
LATENCY, 8, cycles from read acceptance edge to first response beat; >=2

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
mem_req_valid  in  1  request valid
mem_req_ready  out  1  request ready
mem_req_rw  in  1  1 = write, 0 = read
mem_req_addr  in  ADDR_BITS  beat address; low log2(BEATS) bits are ignored
mem_req_tag  in  TAG_BITS  request tag
mem_req_data_valid  in  1  write beat valid
mem_req_data_ready  out  1  write beat ready
mem_req_data_bits  in  DATA_BITS  write beat data
mem_req_data_mask  in  DATA_BITS/8  byte enables; bit i covers byte i
mem_resp_valid  out  1  read beat valid; no backpressure
mem_resp_tag  out  TAG_BITS  tag of the read being returned
mem_resp_data  out  DATA_BITS  read beat data

Behaviour:
- Reset (reset==0, asynchronous): state goes to IDLE and all counters clear. mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0. RAM contents are not cleared.
- Internal RAM is named ram, depth 2^DEPTH_LOG2, width DATA_BITS, so it can be preloaded with $readmemh.
- Line base = {addr[ADDR_BITS-1:log2 BEATS], 0}. Beat k uses RAM index (base+k) mod 2^DEPTH_LOG2; upper address bits are dropped (wrap-around).
- Only one request is outstanding at a time. mem_req_ready is a registered output, equal to 1 exactly while in IDLE, from the first cycle after reset deasserts.
- FSM states: IDLE, WDATA, WAIT, RRESP.
- IDLE: on valid&ready with rw=1, latch base and tag and go to WDATA. With rw=0, latch base and tag, load the latency counter, and go to WAIT.
- WDATA: mem_req_data_ready=1. Each data_valid&data_ready edge writes beat k, for bytes whose mask bit is 1 only, then k++. After the beat with k==BEATS-1, go to IDLE (ready returns the next cycle).
- A data beat presented while in IDLE is not accepted (data_ready=0 there). Data-valid gaps in WDATA simply stall.
- WAIT: counts down. The RAM read of beat 0 is issued one cycle before the first response cycle.
- RRESP: for BEATS consecutive cycles, mem_resp_valid=1, mem_resp_tag=latched tag, mem_resp_data=RAM[base+k]. The first beat appears in the cycle starting LATENCY edges after the acceptance edge. After the last beat, go to IDLE with valid=0.
- Writes produce no response.
- mem_resp_data holds its last value when valid=0; mem_resp_tag is likewise held.
- Read-after-write: a read accepted after write completion returns the new data. No bypass is needed, because the write finishes before IDLE is re-entered.
- Reset asserted mid-burst: the burst is abandoned. Beats already written stay written, and no further response beats are produced.
- Requests arriving while not in IDLE are held by the initiator (ready=0); the responder never drops an accepted request.

Decomposition:
- Widths come from `MEM_DATA_BITS/`MEM_ADDR_BITS/`MEM_TAG_BITS in const.vh.
- FSM state encodings are localparams. A new `MEM_BURST_BEATS define in const.vh is shared with the cache.
- One sub-module: ext_mem_ram. It is a single-port, byte-masked, synchronous-read RAM with parameters DATA_BITS and DEPTH_LOG2. It holds the ram array and registers its read data.

Test Plan:
- Reset, then preload ram[0..3]=A0..A3; read addr=0x0000002, tag=5 -> beats A0..A3 on cycles LATENCY..LATENCY+3 after acceptance, tag=5 on each; ready low throughout the burst.
- Write addr=0x10 with 4 beats of 0xFFFF...; beat 1 mask=0x0001 and data 0x..AB, all other masks 0xFFFF; then read addr=0x10 -> beat 1 has only byte 0 = 0xAB with bytes 1-15 unchanged, other beats all ones.
- Write with data_valid toggling every other cycle -> exactly 4 beats stored, ready returns 1 cycle after the 4th beat, no response pulse.
- Address wrap: read addr=(2^DEPTH_LOG2)+4 -> data equals a read of addr=4.
- Back-to-back: a read request held valid while the previous read bursts -> accepted the cycle after its last beat, two bursts with correct tags and no overlap.
- Assert reset during beat 2 of a read -> all outputs are 0 asynchronously; after release ready=1 and a new read completes normally.
